// File: rtl/alu_pkg.sv
// Shared ALU operation codes, instruction field constants and immediate-extension helpers.
// Both the decode stage and the execute ALU import this package.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRA = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd9;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_XOR = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic {EXT_SIGN, EXT_ZERO} ext_kind_e;

  function automatic logic [31:0] extendImm(input logic [15:0] imm, input ext_kind_e kind);
    return (kind == EXT_ZERO) ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// ID/EX boundary bundle: decode-side inputs plus the registered E-stage control outputs.
// The master drives the instruction and pipeline controls; the slave is the stage itself.
interface alu_ctrl_stage_if #(parameter int CNT_W = 8);
  logic [31:0]      Instr_D;
  logic             valid_D;
  logic             stall_E;
  logic             flush_E;
  logic [3:0]       ALU_Instruction_E;
  logic [4:0]       shamt_E;
  logic             Src_B_Imm_E;
  logic [31:0]      Imm_E;
  logic             valid_E;
  logic             illegal_E;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output Instr_D, valid_D, stall_E, flush_E,
    input  ALU_Instruction_E, shamt_E, Src_B_Imm_E, Imm_E, valid_E, illegal_E, illegal_cnt
  );

  modport slave (
    input  Instr_D, valid_D, stall_E, flush_E,
    output ALU_Instruction_E, shamt_E, Src_B_Imm_E, Imm_E, valid_E, illegal_E, illegal_cnt
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of an ID-stage instruction into ALU code, shamt, operand-B select and immediate.
// Illegal encodings and invalid slots both collapse to an all-zero result.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic        i_valid,
  output logic [3:0]  o_code,
  output logic [4:0]  o_shamt,
  output logic        o_srcBImm,
  output logic [31:0] o_imm,
  output logic        o_illegal
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic [3:0] w_code;
  logic       w_srcBImm;
  logic       w_hasImm;
  logic       w_bad;
  ext_kind_e  w_ext;
  logic       w_unusedRegFields;

  assign w_opcode          = i_instr[31:26];
  assign w_funct           = i_instr[5:0];
  assign w_unusedRegFields = ^i_instr[25:16];

  always_comb begin
    w_code    = ALU_AND;
    w_srcBImm = 1'b0;
    w_hasImm  = 1'b0;
    w_ext     = EXT_SIGN;
    w_bad     = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          F_ADD, F_ADDU: w_code = ALU_ADD;
          F_SUB, F_SUBU: w_code = ALU_SUB;
          F_AND:         w_code = ALU_AND;
          F_OR:          w_code = ALU_OR;
          F_XOR:         w_code = ALU_XOR;
          F_NOR:         w_code = ALU_NOR;
          F_SLT:         w_code = ALU_SLT;
          F_SLL:         w_code = ALU_SLL;
          F_SRL:         w_code = ALU_SRL;
          F_SRA:         w_code = ALU_SRA;
          default:       w_bad  = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        w_code = ALU_ADD; w_srcBImm = 1'b1; w_hasImm = 1'b1;
      end
      OP_SLTI: begin
        w_code = ALU_SLT; w_srcBImm = 1'b1; w_hasImm = 1'b1;
      end
      OP_ANDI: begin
        w_code = ALU_AND; w_srcBImm = 1'b1; w_hasImm = 1'b1; w_ext = EXT_ZERO;
      end
      OP_ORI: begin
        w_code = ALU_OR; w_srcBImm = 1'b1; w_hasImm = 1'b1; w_ext = EXT_ZERO;
      end
      OP_XORI: begin
        w_code = ALU_XOR; w_srcBImm = 1'b1; w_hasImm = 1'b1; w_ext = EXT_ZERO;
      end
      // LUI passes the raw zero-extended immediate; the execute ALU does the shift by 16.
      OP_LUI: begin
        w_code = ALU_LUI; w_srcBImm = 1'b1; w_hasImm = 1'b1; w_ext = EXT_ZERO;
      end
      // Branches compare two registers but still carry the offset for the target adder.
      OP_BEQ, OP_BNE: begin
        w_code = ALU_SUB; w_hasImm = 1'b1;
      end
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    o_code    = ALU_AND;
    o_shamt   = 5'd0;
    o_srcBImm = 1'b0;
    o_imm     = 32'd0;
    o_illegal = 1'b0;
    if (i_valid) begin
      if (w_bad) begin
        o_illegal = 1'b1;
      end else begin
        o_code    = w_code;
        o_srcBImm = w_srcBImm;
        if (w_hasImm) o_imm = extendImm(i_instr[15:0], w_ext);
        if (w_code == ALU_SLL || w_code == ALU_SRL || w_code == ALU_SRA) o_shamt = i_instr[10:6];
      end
    end
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX pipeline register for ALU control, with flush-over-stall priority and a
// saturating count of illegal instructions that actually enter the E stage.
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  alu_ctrl_stage_if.slave bus
);

  logic [3:0]       w_code;
  logic [4:0]       w_shamt;
  logic             w_srcBImm;
  logic [31:0]      w_imm;
  logic             w_illegal;

  logic [3:0]       r_code;
  logic [4:0]       r_shamt;
  logic             r_srcBImm;
  logic [31:0]      r_imm;
  logic             r_valid;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  alu_ctrl_decode u_decode (
    .i_instr   (bus.Instr_D),
    .i_valid   (bus.valid_D),
    .o_code    (w_code),
    .o_shamt   (w_shamt),
    .o_srcBImm (w_srcBImm),
    .o_imm     (w_imm),
    .o_illegal (w_illegal)
  );

  // The counter only advances on a real load, so stalled or flushed illegals are never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code    <= ALU_AND;
      r_shamt   <= 5'd0;
      r_srcBImm <= 1'b0;
      r_imm     <= 32'd0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else if (bus.flush_E) begin
      r_code    <= ALU_AND;
      r_shamt   <= 5'd0;
      r_srcBImm <= 1'b0;
      r_imm     <= 32'd0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (!bus.stall_E) begin
      r_code    <= w_code;
      r_shamt   <= w_shamt;
      r_srcBImm <= w_srcBImm;
      r_imm     <= w_imm;
      r_valid   <= bus.valid_D;
      r_illegal <= w_illegal;
      if (w_illegal && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.ALU_Instruction_E = r_code;
  assign bus.shamt_E           = r_shamt;
  assign bus.Src_B_Imm_E       = r_srcBImm;
  assign bus.Imm_E             = r_imm;
  assign bus.valid_E           = r_valid;
  assign bus.illegal_E         = r_illegal;
  assign bus.illegal_cnt       = r_cnt;

endmodule
